mips_alu_cache_unit: RTL and testbench
======================================

// Module: mips_alu_cache_unit
// PURPOSE
//  Execute/memory slice of the single-cycle MIPS core: ALU-control decode, 32-bit ALU, and a
//  direct-mapped write-through data cache in front of word-wide data memory (4 bytes, big-endian,
//  byte[0]=MSB). The ALU result is the cache address. The core advances PC when cache_en=0 or hit=1.
// PARAMETERS
//  CACHE_LINES  2048  one-word lines; power of 2; INDEX_BITS=log2(CACHE_LINES)
//  MEM_LATENCY  4     cycles memory needs per read/write (>=1)
// PORTS
//  clk             in   1      sole clock, rising edge
//  rst_b           in   1      reset, asynchronous, active-low
//  alu_op          in   4      op from main control; 4'hF = R-type (decode func)
//  func            in   6      instruction[5:0]
//  a, b            in   32     ALU operands (a = rs or shamt; b = rt or immediate)
//  control         out  4      decoded ALU operation
//  alu_result      out  32     ALU result, also the cache address
//  zero            out  1      alu_result==0
//  cache_en        in   1      load/store request
//  cache_write_en  in   1      store, qualifies cache_en
//  cache_data_in   in   8x[0:3] store word (byte merging done by core)
//  cache_data_out  out  8x[0:3] cached word at alu_result
//  hit             out  1      request complete/data valid
//  mem_addr        out  32     word-aligned memory address
//  mem_data_out    in   8x[0:3] memory read data
//  mem_data_in     out  8x[0:3] memory write data
//  mem_write_en    out  1      memory write strobe
// BEHAVIOUR
//  ALU control (comb): alu_op!=F -> control=alu_op. alu_op=F -> func: 20/21->2, 22/23->8, 24->0,
//   25->1, 26->3, 27->4, 2A->9, 2B->A, 00/04->5, 02/06->6, 03/07->7, 18->C, 08 and others->2.
//  ALU (comb): 0 AND,1 OR,2 ADD,3 XOR,4 NOR,5 b<<a[4:0],6 b>>a[4:0] logical,7 b>>>a[4:0] arith,
//   8 a-b,9 signed a<b ?1:0,A unsigned a<b ?1:0,B b<<16,C low 32 bits of a*b,D-F 0.
//   Mod 2^32 arithmetic, no overflow trap.
//  Cache: index=addr[INDEX_BITS+1:2], tag=addr[31:INDEX_BITS+2], addr[1:0] ignored.
//   Per line: valid, tag, 4 data bytes.
//  mem_addr={alu_result[31:2],2'b00} in IDLE; latched request address in FILL/WRITE.
//  cache_data_out = indexed line data at all times (comb).
//  FSM IDLE/FILL/WRITE/RESP, counter cnt:
//   IDLE, cache_en=1, write=0: valid and tag match -> hit=1 same cycle, no state change.
//    Otherwise -> FILL; latch addr; cnt=MEM_LATENCY-1.
//   IDLE, cache_en=1, write=1 -> WRITE; latch addr and cache_data_in; cnt=MEM_LATENCY-1.
//   FILL: hit=0; cnt decrements. At cnt=0 write mem_data_out, tag and valid into line; -> IDLE.
//    The retry then hits: read miss hit rises at cycle MEM_LATENCY+1.
//   WRITE: mem_write_en=1 and mem_data_in=latched data every cycle; at cnt=0 write line
//    (write-allocate); -> RESP.
//   RESP: hit=1 for exactly one cycle regardless of inputs; -> IDLE. cache_write_en is ignored.
//   cache_en=0 in IDLE: hit=0, no activity. Deasserting mid-FILL/WRITE does not abort; the
//    transaction completes.
//  mem_write_en=0 and mem_data_in=0 outside WRITE.
//  Reset (async): state=IDLE, cnt=0, all valid=0; hit=0, mem_write_en=0.
//   Data/tag arrays are not reset. Reset mid-FILL/WRITE abandons the transaction with no line update.
// TESTING
//  alu_op=F func=22 a=5 b=7 -> control=8, alu_result=FFFFFFFE, zero=0; func=2A -> result=1.
//  alu_op=F func=03 a=4 b=80000000 -> 0xF8000000; alu_op=B b=1234 -> 0x12340000.
//  Reset, read addr 0x40 (mem holds 0xDEADBEEF) -> hit=0 for 4 cycles; then hit=1,
//   cache_data_out=DE,AD,BE,EF; a repeat read hits at once.
//  Store 0x11223344 to 0x80 -> mem_write_en=1 for 4 cycles, mem_addr=0x80; RESP hit=1 one cycle;
//   next read of 0x80 hits with 11,22,33,44.
//  Conflict: read 0x40, then 0x40+4*CACHE_LINES (same index) -> miss and refill; 0x40 misses again.
//  Assert rst_b mid-FILL -> hit=0 and mem_write_en=0 at once; the previously filled line misses.

Source files
------------

// File: rtl/mips_alu_cache_unit.sv
// Execute/memory slice of a single-cycle MIPS core: ALU-control decode,
// 32-bit ALU and a direct-mapped write-through, write-allocate data cache
// sitting in front of a word-wide data memory with fixed access latency.
module mips_alu_cache_unit #(
  parameter int unsigned CACHE_LINES = 2048,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic [3:0]       control,
  output logic [31:0]      alu_result,
  output logic             zero,
  input  logic             cache_en,
  input  logic             cache_write_en,
  input  logic [0:3][7:0]  cache_data_in,
  output logic [0:3][7:0]  cache_data_out,
  output logic             hit,
  output logic [31:0]      mem_addr,
  input  logic [0:3][7:0]  mem_data_out,
  output logic [0:3][7:0]  mem_data_in,
  output logic             mem_write_en
);

  localparam int unsigned INDEX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;
  localparam int unsigned CNT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [29:0]             req_addr;
  logic [0:3][7:0]         req_data;

  logic [CACHE_LINES-1:0]  valid;
  logic [TAG_BITS-1:0]     tag_mem  [CACHE_LINES];
  logic [0:3][7:0]         data_mem [CACHE_LINES];

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]     tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]     req_tag;
  logic                    lookup_hit;
  logic                    fill_done;
  logic                    write_done;
  logic [4:0]              shamt;

  // ALU control: main-control op passes through, R-type decodes func
  always_comb begin
    control = alu_op;
    if (alu_op == 4'hF) begin
      case (func)
        6'h20, 6'h21: control = 4'h2;
        6'h22, 6'h23: control = 4'h8;
        6'h24:        control = 4'h0;
        6'h25:        control = 4'h1;
        6'h26:        control = 4'h3;
        6'h27:        control = 4'h4;
        6'h2A:        control = 4'h9;
        6'h2B:        control = 4'hA;
        6'h00, 6'h04: control = 4'h5;
        6'h02, 6'h06: control = 4'h6;
        6'h03, 6'h07: control = 4'h7;
        6'h18:        control = 4'hC;
        default:      control = 4'h2;
      endcase
    end
  end

  assign shamt = a[4:0];

  // ALU datapath, modulo 2^32, no overflow detection
  always_comb begin
    alu_result = '0;
    case (control)
      4'h0: alu_result = a & b;
      4'h1: alu_result = a | b;
      4'h2: alu_result = a + b;
      4'h3: alu_result = a ^ b;
      4'h4: alu_result = ~(a | b);
      4'h5: alu_result = b << shamt;
      4'h6: alu_result = b >> shamt;
      4'h7: alu_result = $signed(b) >>> shamt;
      4'h8: alu_result = a - b;
      4'h9: alu_result = {31'b0, $signed(a) < $signed(b)};
      4'hA: alu_result = {31'b0, a < b};
      4'hB: alu_result = {b[15:0], 16'h0000};
      4'hC: alu_result = a * b;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  assign idx     = alu_result[INDEX_BITS+1:2];
  assign tag     = alu_result[31:INDEX_BITS+2];
  assign req_idx = req_addr[INDEX_BITS-1:0];
  assign req_tag = req_addr[29:INDEX_BITS];

  assign lookup_hit     = valid[idx] && (tag_mem[idx] == tag);
  assign cache_data_out = data_mem[idx];

  assign fill_done  = (state == FILL)  && (cnt == '0);
  assign write_done = (state == WRITE) && (cnt == '0);

  assign hit = (state == RESP) ||
               ((state == IDLE) && cache_en && !cache_write_en && lookup_hit);

  assign mem_addr     = (state == IDLE) ? {alu_result[31:2], 2'b00} : {req_addr, 2'b00};
  assign mem_write_en = (state == WRITE);
  assign mem_data_in  = (state == WRITE) ? req_data : '0;

  // Tag/data arrays: unreset storage, updated only when a transaction completes
  always_ff @(posedge clk) begin
    if (fill_done || write_done) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= fill_done ? mem_data_out : req_data;
    end
  end

  // Controller: request latch, latency counter and line valid bits
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
      req_data <= '0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cache_en) begin
            req_addr <= alu_result[31:2];
            req_data <= cache_data_in;
            cnt      <= CNT_W'(MEM_LATENCY - 1);
            if (cache_write_en)  state <= WRITE;
            else if (!lookup_hit) state <= FILL;
          end
        end
        FILL: begin
          if (cnt == '0) begin
            valid[req_idx] <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            valid[req_idx] <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_cache_unit.sv
// Directed bench for mips_alu_cache_unit: ALU decode/datapath vectors,
// read miss/fill, store with write-allocate, index conflict and reset abort.
module tb_mips_alu_cache_unit;

  logic             clk = 1'b0;
  logic             rst_b;
  logic [3:0]       alu_op;
  logic [5:0]       func;
  logic [31:0]      a, b;
  logic [3:0]       control;
  logic [31:0]      alu_result;
  logic             zero;
  logic             cache_en;
  logic             cache_write_en;
  logic [0:3][7:0]  cache_data_in;
  logic [0:3][7:0]  cache_data_out;
  logic             hit;
  logic [31:0]      mem_addr;
  logic [0:3][7:0]  mem_data_out;
  logic [0:3][7:0]  mem_data_in;
  logic             mem_write_en;

  int errors = 0;
  int checks = 0;

  mips_alu_cache_unit #(.CACHE_LINES(2048), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_b(rst_b), .alu_op(alu_op), .func(func), .a(a), .b(b),
    .control(control), .alu_result(alu_result), .zero(zero),
    .cache_en(cache_en), .cache_write_en(cache_write_en),
    .cache_data_in(cache_data_in), .cache_data_out(cache_data_out), .hit(hit),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en)
  );

  always #5 clk = ~clk;

  // Data memory contents seen by refills
  always_comb begin
    case (mem_addr)
      32'h0000_0040: mem_data_out = 32'hDEAD_BEEF;
      32'h0000_2040: mem_data_out = 32'hCAFE_F00D;
      default:       mem_data_out = 32'h0BAD_0000 | mem_addr;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] addr);
    alu_op = 4'h2;
    func   = 6'h00;
    a      = addr;
    b      = 32'h0;
  endtask

  initial begin
    rst_b = 1'b0; alu_op = 4'h0; func = 6'h00; a = '0; b = '0;
    cache_en = 1'b0; cache_write_en = 1'b0; cache_data_in = '0;
    #1;
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_mwe", {31'b0, mem_write_en}, 32'd0);
    chk("rst_mdi", mem_data_in, 32'h0);

    // ALU vectors
    alu_op = 4'hF; func = 6'h22; a = 32'd5; b = 32'd7; #1;
    chk("sub_ctl", {28'b0, control}, 32'h8);
    chk("sub_res", alu_result, 32'hFFFF_FFFE);
    chk("sub_zero", {31'b0, zero}, 32'd0);
    func = 6'h2A; #1;
    chk("slt_res", alu_result, 32'h1);
    func = 6'h03; a = 32'd4; b = 32'h8000_0000; #1;
    chk("sra_res", alu_result, 32'hF800_0000);
    func = 6'h02; #1;
    chk("srl_res", alu_result, 32'h0800_0000);
    alu_op = 4'hB; b = 32'h1234; #1;
    chk("lui_ctl", {28'b0, control}, 32'hB);
    chk("lui_res", alu_result, 32'h1234_0000);
    alu_op = 4'hF; func = 6'h24; a = 32'hF0F0; b = 32'hFF00; #1;
    chk("and_res", alu_result, 32'h0000_F000);
    func = 6'h27; a = 32'h0; b = 32'h0; #1;
    chk("nor_res", alu_result, 32'hFFFF_FFFF);
    func = 6'h2B; a = 32'h1; b = 32'hFFFF_FFFF; #1;
    chk("sltu_res", alu_result, 32'h1);
    func = 6'h2A; #1;
    chk("slt_neg", alu_result, 32'h0);
    func = 6'h18; a = 32'd3; b = 32'd7; #1;
    chk("mul_ctl", {28'b0, control}, 32'hC);
    chk("mul_res", alu_result, 32'd21);
    func = 6'h00; a = 32'h21; b = 32'h1; #1;
    chk("sll_shamt5", alu_result, 32'h2);
    func = 6'h08; #1;
    chk("jr_ctl", {28'b0, control}, 32'h2);
    func = 6'h23; a = 32'd5; b = 32'd5; #1;
    chk("subu_zero", {31'b0, zero}, 32'd1);
    alu_op = 4'hD; a = 32'h1; b = 32'h1; #1;
    chk("op_d_res", alu_result, 32'h0);

    // Leave reset away from the clock edge
    step();
    rst_b = 1'b1;
    set_addr(32'h40); #1;
    chk("idle_hit", {31'b0, hit}, 32'd0);

    // Read miss with refill
    cache_en = 1'b1; #1;
    chk("rd_miss_hit", {31'b0, hit}, 32'd0);
    chk("rd_maddr", mem_addr, 32'h40);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_hit", {31'b0, hit}, 32'd0);
    end
    step();
    chk("rd_fill_hit", {31'b0, hit}, 32'd1);
    chk("rd_fill_data", cache_data_out, 32'hDEAD_BEEF);
    step();
    chk("rd_repeat_hit", {31'b0, hit}, 32'd1);
    cache_en = 1'b0; #1;
    chk("dis_hit", {31'b0, hit}, 32'd0);

    // Store with write-allocate; request dropped mid-transaction
    set_addr(32'h80);
    cache_data_in = 32'h1122_3344; cache_en = 1'b1; cache_write_en = 1'b1; #1;
    chk("st_idle_hit", {31'b0, hit}, 32'd0);
    chk("st_idle_mwe", {31'b0, mem_write_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      cache_en = 1'b0; cache_write_en = 1'b0; cache_data_in = 32'h0;
      set_addr(32'h44); #1;
      chk("st_mwe", {31'b0, mem_write_en}, 32'd1);
      chk("st_maddr", mem_addr, 32'h80);
      chk("st_mdi", mem_data_in, 32'h1122_3344);
      chk("st_busy_hit", {31'b0, hit}, 32'd0);
    end
    step();
    chk("resp_hit", {31'b0, hit}, 32'd1);
    chk("resp_mwe", {31'b0, mem_write_en}, 32'd0);
    chk("resp_mdi", mem_data_in, 32'h0);
    step();
    chk("post_resp_hit", {31'b0, hit}, 32'd0);
    set_addr(32'h80); cache_en = 1'b1; #1;
    chk("st_rd_hit", {31'b0, hit}, 32'd1);
    chk("st_rd_data", cache_data_out, 32'h1122_3344);

    // Index conflict: 0x2040 evicts 0x40
    set_addr(32'h2040); #1;
    chk("cf_miss", {31'b0, hit}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("cf_hit", {31'b0, hit}, 32'd1);
    chk("cf_data", cache_data_out, 32'hCAFE_F00D);
    set_addr(32'h40); #1;
    chk("cf_old_miss", {31'b0, hit}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("cf_old_hit", {31'b0, hit}, 32'd1);
    chk("cf_old_data", cache_data_out, 32'hDEAD_BEEF);

    // Reset mid-FILL
    set_addr(32'h2080); #1;
    step(); step();
    chk("pre_rst_busy", {31'b0, hit}, 32'd0);
    rst_b = 1'b0; #1;
    chk("rst_fill_hit", {31'b0, hit}, 32'd0);
    chk("rst_fill_mwe", {31'b0, mem_write_en}, 32'd0);
    chk("rst_fill_maddr", mem_addr, 32'h2080);
    step();
    rst_b = 1'b1; set_addr(32'h40); #1;
    chk("rst_old_miss", {31'b0, hit}, 32'd0);
    cache_en = 1'b0; #1;

    // Reset mid-WRITE
    set_addr(32'hC0); cache_data_in = 32'h5566_7788;
    cache_en = 1'b1; cache_write_en = 1'b1; #1;
    step();
    cache_en = 1'b0; cache_write_en = 1'b0; #1;
    chk("wr_busy_mwe", {31'b0, mem_write_en}, 32'd1);
    rst_b = 1'b0; #1;
    chk("rst_wr_mwe", {31'b0, mem_write_en}, 32'd0);
    chk("rst_wr_mdi", mem_data_in, 32'h0);
    step();
    rst_b = 1'b1; cache_en = 1'b1; #1;
    chk("rst_wr_line_miss", {31'b0, hit}, 32'd0);
    cache_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
